// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : RISC-V MEM stage; runs loads/stores over a req/done handshake
//            and sign/zero-extends load data before writeback.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] ma_addr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [2:0]  mem_len_o,
    input  logic        mem_done_i,
    input  logic [31:0] mem_rdata_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o
);

    localparam logic [7:0] C_EXE_LB_OP   = 8'b1110_0000;
    localparam logic [7:0] C_EXE_LH_OP   = 8'b1110_0001;
    localparam logic [7:0] C_EXE_LW_OP   = 8'b1110_0011;
    localparam logic [7:0] C_EXE_LBU_OP  = 8'b1110_0100;
    localparam logic [7:0] C_EXE_LHU_OP  = 8'b1110_0101;
    localparam logic [7:0] C_EXE_SB_OP   = 8'b1110_1000;
    localparam logic [7:0] C_EXE_SH_OP   = 8'b1110_1001;
    localparam logic [7:0] C_EXE_SW_OP   = 8'b1110_1011;
    localparam logic [4:0] C_NOP_REG_ADDR = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_rdata_q;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic [2:0]  w_len;
    logic [31:0] w_load_ext;
    logic        w_unused;

    assign w_unused = ^{stall[5], stall[3:0], alusel_i};

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_len      = 3'd4;
        case (aluop_i)
            C_EXE_LB_OP, C_EXE_LBU_OP: begin w_is_load  = 1'b1; w_len = 3'd1; end
            C_EXE_LH_OP, C_EXE_LHU_OP: begin w_is_load  = 1'b1; w_len = 3'd2; end
            C_EXE_LW_OP:               begin w_is_load  = 1'b1; w_len = 3'd4; end
            C_EXE_SB_OP:               begin w_is_store = 1'b1; w_len = 3'd1; end
            C_EXE_SH_OP:               begin w_is_store = 1'b1; w_len = 3'd2; end
            C_EXE_SW_OP:               begin w_is_store = 1'b1; w_len = 3'd4; end
            default: ;
        endcase
        w_is_mem = w_is_load | w_is_store;
    end

    always_comb begin
        case (aluop_i)
            C_EXE_LB_OP:  w_load_ext = {{24{r_rdata_q[7]}},  r_rdata_q[7:0]};
            C_EXE_LBU_OP: w_load_ext = {24'd0,               r_rdata_q[7:0]};
            C_EXE_LH_OP:  w_load_ext = {{16{r_rdata_q[15]}}, r_rdata_q[15:0]};
            C_EXE_LHU_OP: w_load_ext = {16'd0,               r_rdata_q[15:0]};
            default:      w_load_ext = r_rdata_q;
        endcase
    end

    // Leaving DONE only via IDLE guarantees a held op is never reissued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rdata_q <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_is_mem) r_state <= ST_BUSY;
                ST_BUSY: begin
                    if (mem_done_i) begin
                        r_rdata_q <= mem_rdata_i;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: if (!stall[4]) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wd_o        = C_NOP_REG_ADDR;
        wreg_o      = 1'b0;
        wdata_o     = 32'd0;
        stallreq_o  = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        mem_len_o   = 3'd0;
        if (!rst) begin
            wd_o = wd_i;
            if ((r_state == ST_BUSY) || ((r_state == ST_IDLE) && w_is_mem)) begin
                // Load result stays zero here so nothing stale is forwarded.
                mem_req_o   = 1'b1;
                stallreq_o  = 1'b1;
                mem_we_o    = w_is_store;
                mem_addr_o  = ma_addr_i;
                mem_wdata_o = wdata_i;
                mem_len_o   = w_len;
            end else if ((r_state == ST_DONE) && w_is_mem) begin
                if (w_is_load) begin
                    wreg_o  = wreg_i;
                    wdata_o = w_load_ext;
                end
            end else begin
                wreg_o  = wreg_i;
                wdata_o = wdata_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the RISC-V core, fed directly by the EX/MEM pipeline register; its outputs feed the MEM/WB register.
- Non-memory instructions pass through combinationally with zero latency.
- Loads and stores run a multi-cycle request/done handshake with the memory controller and hold the pipeline through `stallreq_o` until the access completes.
- Load data is sign- or zero-extended before writeback.

Parameters:
- none

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high (`RstEnable`)
- stall  in  6  ctrl stall bus; bit 4 = MEM stage held, bit 5 = WB stage held
- wd_i  in  5  destination register from EX/MEM
- wreg_i  in  1  write enable from EX/MEM
- wdata_i  in  32  ALU result, or store data for stores
- aluop_i  in  8  operation code (`EXE_*_OP`)
- alusel_i  in  3  result class (`EXE_RES_*`)
- ma_addr_i  in  32  effective memory address
- mem_req_o  out  1  access request to memory controller
- mem_we_o  out  1  1 = store, 0 = load
- mem_addr_o  out  32  access address
- mem_wdata_o  out  32  store data, low bytes significant
- mem_len_o  out  3  access length in bytes: 1, 2 or 4
- mem_done_i  in  1  one-cycle pulse: access complete
- mem_rdata_i  in  32  load data, zero-padded above length; valid with `mem_done_i`
- wd_o  out  5  to MEM/WB
- wreg_o  out  1  to MEM/WB
- wdata_o  out  32  to MEM/WB
- stallreq_o  out  1  stall request to ctrl

Behaviour:
- FSM states: IDLE, BUSY, DONE. Registers: state; `rdata_q` (32 b).
- Memory op = `aluop_i` in {LB, LH, LW, LBU, LHU, SB, SH, SW}.
- Reset: next edge with `rst`=1 forces IDLE and `rdata_q`=0. While `rst`=1, all outputs are gated combinationally to 0 (wd `NOPRegAddr`, wreg `WriteDisable`).
- Reset mid-access: `mem_req_o` drops the same cycle `rst` is asserted; the memory controller treats a dropped req as abort.
- `wd_o` = `wd_i` always.
- Non-memory op in IDLE: `wreg_o`=`wreg_i`, `wdata_o`=`wdata_i`, `stallreq_o`=0, `mem_req_o`=0.
- IDLE with memory op:
  - Assert `mem_req_o` and `stallreq_o`; go to BUSY on the edge.
  - `mem_addr_o`=`ma_addr_i`; `mem_we_o`=1 for stores.
  - `mem_len_o`=1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
  - `mem_wdata_o`=`wdata_i`.
  - `mem_done_i` in IDLE is ignored.
- BUSY:
  - `mem_req_o`, request fields and `stallreq_o` held at 1.
  - Inputs are held stable by the upstream stall.
  - On `mem_done_i`=1: `rdata_q` <= `mem_rdata_i`; go to DONE.
  - No timeout.
- DONE:
  - `mem_req_o`=0, `stallreq_o`=0.
  - Load: `wreg_o`=`wreg_i`; `wdata_o` from `rdata_q`:
    - LB: sign-extend bit 7.
    - LBU: zero-extend [7:0].
    - LH: sign-extend bit 15.
    - LHU: zero-extend [15:0].
    - LW: [31:0].
  - Store: `wreg_o`=0, `wdata_o`=0.
  - If `stall[4]`=Stop, stay in DONE and keep driving the result. Otherwise go to IDLE on the next edge, without reissuing the access.
- While IDLE/BUSY on a load: `wreg_o`=0 and `wdata_o`=0, so no forwarding of stale data.
- The same memory op is never issued twice; a new access requires passing through IDLE.
- `mem_done_i` outside BUSY is ignored.
- No alignment checking; the controller handles unaligned addresses.
- Back-to-back memory ops: each takes at least 3 cycles (IDLE, BUSY, DONE), assuming `mem_done_i` arrives in the first BUSY cycle.

Test Plan:
- ADD, `wd_i`=5, `wdata_i`=0x1234 -> same cycle `wd_o`=5, `wreg_o`=1, `wdata_o`=0x1234, `stallreq_o`=0, `mem_req_o`=0.
- LB at 0x100, done after 3 BUSY cycles with rdata 0x80 -> `mem_len_o`=1, `mem_we_o`=0, `stallreq_o`=1 for IDLE+3 cycles; DONE `wdata_o`=0xFFFFFF80, `wreg_o`=1.
- LHU rdata 0x8001 -> 0x00008001. LH rdata 0x8001 -> 0xFFFF8001. LW 0xDEADBEEF -> 0xDEADBEEF.
- SW addr 0x2000, data 0xCAFEF00D -> `mem_we_o`=1, `mem_len_o`=4, fields stable until done; DONE `wreg_o`=0; exactly one request.
- DONE with `stall[4]`=1 for 2 cycles -> remains DONE, `wdata_o` stable, `mem_req_o`=0; returns to IDLE after release.
- `rst` pulsed while BUSY -> `mem_req_o`=0 that cycle, IDLE next edge; a late `mem_done_i` is ignored and `rdata_q` stays 0.
